// File: rtl/counter_pkg.sv
// Shared constants and helpers for the chronometer counter stages.
package counter_pkg;

  // Deepest synchroniser chain an edge_sync instance will build.
  localparam int MAX_SYNC_STAGES = 3;

  // Widest counter supported; also the width of the modulus helper's input.
  localparam int MAX_WIDTH = 32;

  // Count direction encoding on the dir input.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Effective modulus: a limit of zero stands for 2^width, so the result
  // needs one bit more than the widest limit.
  function automatic logic [MAX_WIDTH:0] eff_modulus(
    input logic [MAX_WIDTH-1:0] limit,
    input int                   width
  );
    logic [MAX_WIDTH:0] m;
    if (limit == '0) begin
      m = {{MAX_WIDTH{1'b0}}, 1'b1} << width;
    end else begin
      m = {1'b0, limit};
    end
    return m;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Count-event front end: optional synchroniser chain, edge history flop and
// enable gating. Shared by every chronometer stage.
module edge_sync
  import counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic qzt_clk,
  input  logic reset,
  input  logic enable,
  input  logic d_in,
  output logic event_out
);

  // Chains deeper than the supported maximum are clamped.
  localparam int STAGES = (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : SYNC_STAGES;

  logic w_s;
  logic w_raw_event;

  generate
    if (STAGES == 0) begin : g_no_sync
      // On-chip cascading: the source is already in the qzt_clk domain.
      assign w_s = d_in;
    end else begin : g_sync
      logic [STAGES-1:0] r_sync;

      // Shift the raw input through the synchroniser chain.
      always_ff @(posedge qzt_clk) begin
        if (reset) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= d_in;
          for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign w_s = r_sync[STAGES-1];
    end

    if (EDGE_MODE == 1) begin : g_edge
      logic r_prev;

      // Track the synchronised level regardless of enable, so re-enabling
      // during a high level does not look like a fresh rising edge.
      always_ff @(posedge qzt_clk) begin
        if (reset) begin
          r_prev <= 1'b0;
        end else begin
          r_prev <= w_s;
        end
      end

      assign w_raw_event = w_s & ~r_prev;
    end else begin : g_level
      // Level mode: every cycle the synchronised input is high is an event.
      assign w_raw_event = w_s;
    end
  endgenerate

  assign event_out = enable & w_raw_event;

endmodule

// File: rtl/counter_sync_updown.sv
// Synchronous up/down modulo counter with runtime limit, parallel load and
// one-cycle carry/borrow pulses for chaining chronometer stages.
module counter_sync_updown
  import counter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic             qzt_clk,
  input  logic             reset,
  input  logic             cnt_in,
  input  logic             enable,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             borrow,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic                 w_event;
  logic [MAX_WIDTH-1:0] w_limit_ext;
  logic [WIDTH:0]       w_mod;
  logic [WIDTH:0]       w_mod_m1;
  logic [WIDTH:0]       w_out_ext;
  logic [WIDTH-1:0]     w_out_next;
  logic                 w_carry_next;
  logic                 w_borrow_next;

  logic [WIDTH-1:0]     r_out;
  logic                 r_carry;
  logic                 r_borrow;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_MODE   (EDGE_MODE)
  ) u_edge_sync (
    .qzt_clk   (qzt_clk),
    .reset     (reset),
    .enable    (enable),
    .d_in      (cnt_in),
    .event_out (w_event)
  );

  // Modulus arithmetic runs one bit wider than the count so 2^WIDTH fits.
  assign w_limit_ext = MAX_WIDTH'(limit);
  assign w_mod       = (WIDTH+1)'(eff_modulus(w_limit_ext, WIDTH));
  assign w_mod_m1    = w_mod - ONE_EXT;
  assign w_out_ext   = {1'b0, r_out};

  // Next count and wrap flags: load beats a count event; limit and dir only
  // matter in an event cycle.
  always_comb begin
    w_out_next    = r_out;
    w_carry_next  = 1'b0;
    w_borrow_next = 1'b0;
    if (load) begin
      w_out_next = load_val;
    end else if (w_event) begin
      if (dir == DIR_UP) begin
        // ">=" also catches a count left above a freshly lowered limit.
        if (w_out_ext >= w_mod_m1) begin
          w_out_next   = '0;
          w_carry_next = 1'b1;
        end else begin
          w_out_next = r_out + ONE;
        end
      end else begin
        if (r_out == '0) begin
          w_out_next    = w_mod_m1[WIDTH-1:0];
          w_borrow_next = 1'b1;
        end else if (w_out_ext >= w_mod) begin
          // Count stranded above the limit snaps to the top without a borrow.
          w_out_next = w_mod_m1[WIDTH-1:0];
        end else begin
          w_out_next = r_out - ONE;
        end
      end
    end
  end

  // Count register and registered wrap pulses.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      r_out    <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_out    <= w_out_next;
      r_carry  <= w_carry_next;
      r_borrow <= w_borrow_next;
    end
  end

  assign out    = r_out;
  assign carry  = r_carry;
  assign borrow = r_borrow;
  assign at_max = (w_out_ext == w_mod_m1);

endmodule

// File: tb/tb_counter_sync_updown.sv
// Bench for counter_sync_updown: default edge-mode instance, a 4-bit
// level-mode instance, and a two-stage cascade.
module tb_counter_sync_updown;
  import counter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A: WIDTH=8, SYNC=2, EDGE=1 ----------------
  logic       a_cnt = 1'b0, a_en = 1'b1, a_dir = DIR_UP, a_load = 1'b0;
  logic [7:0] a_load_val = '0, a_limit = 8'd10;
  logic [7:0] a_out;
  logic       a_carry, a_borrow, a_at_max;

  counter_sync_updown #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(1)) dut_a (
    .qzt_clk(clk), .reset(reset), .cnt_in(a_cnt), .enable(a_en), .dir(a_dir),
    .load(a_load), .load_val(a_load_val), .limit(a_limit),
    .out(a_out), .carry(a_carry), .borrow(a_borrow), .at_max(a_at_max)
  );

  // ---------------- instance B: WIDTH=4, SYNC=0, EDGE=0 ----------------
  logic       b_cnt = 1'b0, b_en = 1'b1, b_dir = DIR_UP, b_load = 1'b0;
  logic [3:0] b_load_val = '0, b_limit = '0;
  logic [3:0] b_out;
  logic       b_carry, b_borrow, b_at_max;

  counter_sync_updown #(.WIDTH(4), .SYNC_STAGES(0), .EDGE_MODE(0)) dut_b (
    .qzt_clk(clk), .reset(reset), .cnt_in(b_cnt), .enable(b_en), .dir(b_dir),
    .load(b_load), .load_val(b_load_val), .limit(b_limit),
    .out(b_out), .carry(b_carry), .borrow(b_borrow), .at_max(b_at_max)
  );

  // ---------------- cascade C1 -> C2 ----------------
  logic       c_cnt = 1'b0, c_en = 1'b1, c_dir = DIR_UP, c_load = 1'b0;
  logic [7:0] c_load_val = '0, c_limit = 8'd10;
  logic [7:0] c1_out, c2_out;
  logic       c1_carry, c1_borrow, c1_at_max, c2_carry, c2_borrow, c2_at_max;

  counter_sync_updown #(.WIDTH(8), .SYNC_STAGES(0), .EDGE_MODE(0)) dut_c1 (
    .qzt_clk(clk), .reset(reset), .cnt_in(c_cnt), .enable(c_en), .dir(c_dir),
    .load(c_load), .load_val(c_load_val), .limit(c_limit),
    .out(c1_out), .carry(c1_carry), .borrow(c1_borrow), .at_max(c1_at_max)
  );

  counter_sync_updown #(.WIDTH(8), .SYNC_STAGES(0), .EDGE_MODE(0)) dut_c2 (
    .qzt_clk(clk), .reset(reset), .cnt_in(c1_carry), .enable(c_en), .dir(c_dir),
    .load(c_load), .load_val(c_load_val), .limit(c_limit),
    .out(c2_out), .carry(c2_carry), .borrow(c2_borrow), .at_max(c2_at_max)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one count event: returns {carry, borrow, next}.
  function automatic logic [33:0] model_step(input int w, input logic [31:0] cur,
                                             input logic d, input logic [31:0] lim);
    longint m;
    longint c;
    c = longint'(cur);
    if (lim == 0) m = longint'(1) << w;
    else          m = longint'(lim);
    if (d == DIR_UP) begin
      if (c >= m - 1) return {2'b10, 32'd0};
      return {2'b00, 32'(c + 1)};
    end
    if (c == 0)  return {2'b01, 32'(m - 1)};
    if (c >= m)  return {2'b00, 32'(m - 1)};
    return {2'b00, 32'(c - 1)};
  endfunction

  // ---------------- scoreboards ----------------
  logic [9:0] exp_a_q[$];   // {carry, borrow, out} for A, one per output change
  logic [5:0] exp_b_q[$];   // {carry, borrow, out} for B, one per driven cycle
  logic [31:0] a_model = '0;
  logic [3:0]  b_model = '0;
  logic [7:0]  a_last = '0;
  int b_carries = 0;
  int c1_carries = 0;
  int c2_carries = 0;

  // A: compare whenever the DUT produces a visible result.
  always @(posedge clk) begin
    #2;
    if (a_out != a_last || a_carry || a_borrow) begin
      if (exp_a_q.size() == 0)
        check("a_spurious", {22'd0, a_carry, a_borrow, a_out}, {24'd0, a_last});
      else
        check("a_sb", {22'd0, a_carry, a_borrow, a_out}, {22'd0, exp_a_q.pop_front()});
    end
    a_last = a_out;
  end

  // B: lockstep, one expected result per driven cycle.
  always @(posedge clk) begin
    #2;
    if (b_carry) b_carries++;
    if (exp_b_q.size() != 0)
      check("b_sb", {26'd0, b_carry, b_borrow, b_out}, {26'd0, exp_b_q.pop_front()});
  end

  always @(negedge clk) begin
    if (c1_carry) c1_carries++;
    if (c2_carry) c2_carries++;
  end

  // ---------------- driver tasks ----------------
  logic [7:0] a_at2_out, a_at3_out;
  logic       a_at3_carry, a_at3_borrow, a_at3_atmax, a_at4_carry, a_at4_borrow;

  // One cnt_in pulse on A, hi cycles high then 4 low; samples around the
  // expected update edge (edge 3 after the rise).
  task automatic a_event(input logic d, input int hi);
    logic [33:0] r;
    r = model_step(8, a_model, d, {24'd0, a_limit});
    a_model = r[31:0];
    exp_a_q.push_back({r[33:32], r[7:0]});
    @(negedge clk); a_dir = d; a_cnt = 1'b1;
    @(negedge clk);
    @(negedge clk); a_at2_out = a_out;
    @(negedge clk); a_at3_out = a_out; a_at3_carry = a_carry;
                    a_at3_borrow = a_borrow; a_at3_atmax = a_at_max;
    @(negedge clk); a_at4_carry = a_carry; a_at4_borrow = a_borrow;
    repeat (hi - 4) @(negedge clk);
    a_cnt = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic a_load_only(input logic [7:0] v);
    exp_a_q.push_back({2'b00, v});
    a_model = {24'd0, v};
    @(negedge clk); a_load = 1'b1; a_load_val = v;
    @(negedge clk); a_load = 1'b0;
    @(negedge clk);
  endtask

  task automatic b_cycle(input logic cnt, input logic d, input logic ld,
                         input logic [3:0] lv, input logic [3:0] lim);
    logic [33:0] r;
    r = '0;
    @(negedge clk);
    b_cnt = cnt; b_dir = d; b_load = ld; b_load_val = lv; b_limit = lim;
    if (ld) begin
      b_model = lv;
    end else if (cnt) begin
      r = model_step(4, {28'd0, b_model}, d, {28'd0, lim});
      b_model = r[3:0];
    end
    exp_b_q.push_back({r[33:32], b_model});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_a_out", {24'd0, a_out}, 32'd0);
    check("rst_a_flags", {29'd0, a_carry, a_borrow, a_at_max}, 32'd0);
    check("rst_b_out", {28'd0, b_out}, 32'd0);
    check("rst_c_out", {16'd0, c1_out, c2_out}, 32'd0);

    // Up count, limit 10: 1..9, 0, 1, 2 with carry at the 10th edge.
    for (int i = 1; i <= 12; i++) begin
      a_event(DIR_UP, 4);
      check("a_up_out", {24'd0, a_at3_out}, i % 10);
      if (i == 9) check("a_at_max9", {31'd0, a_at3_atmax}, 32'd1);
      if (i == 10) begin
        check("a_latency_before", {24'd0, a_at2_out}, 32'd9);
        check("a_carry_at_wrap", {31'd0, a_at3_carry}, 32'd1);
        check("a_carry_one_cycle", {31'd0, a_at4_carry}, 32'd0);
      end else begin
        check("a_no_carry", {31'd0, a_at3_carry}, 32'd0);
      end
    end

    // Down from 0 wraps to 9 with borrow, then plain 8.
    a_load_only(8'd0);
    a_event(DIR_DOWN, 4);
    check("a_down_wrap", {24'd0, a_at3_out}, 32'd9);
    check("a_borrow_pulse", {31'd0, a_at3_borrow}, 32'd1);
    check("a_borrow_one_cycle", {31'd0, a_at4_borrow}, 32'd0);
    a_event(DIR_DOWN, 4);
    check("a_down_plain", {24'd0, a_at3_out}, 32'd8);
    check("a_no_borrow", {31'd0, a_at3_borrow}, 32'd0);

    // Load coincident with an event: load wins, event dropped.
    exp_a_q.push_back({2'b00, 8'd7});
    a_model = 32'd7;
    @(negedge clk); a_dir = DIR_UP; a_cnt = 1'b1;
    @(negedge clk);
    @(negedge clk); a_load = 1'b1; a_load_val = 8'd7;
    @(negedge clk); a_load = 1'b0;
    check("a_load_wins", {23'd0, a_carry, a_out}, 32'd7);
    repeat (4) @(negedge clk); a_cnt = 1'b0;
    repeat (4) @(negedge clk);
    check("a_load_no_late", {24'd0, a_out}, 32'd7);

    // Long high level in edge mode counts once.
    a_event(DIR_UP, 20);
    check("a_hold_once", {24'd0, a_out}, 32'd8);

    // Rising edge while disabled, re-enabled during the high level: no count.
    @(negedge clk); a_en = 1'b0; a_cnt = 1'b1;
    repeat (4) @(negedge clk); a_en = 1'b1;
    repeat (6) @(negedge clk); a_cnt = 1'b0;
    repeat (4) @(negedge clk);
    check("a_enable_gate", {24'd0, a_out}, 32'd8);

    // Count above a lowered limit: up event wraps to 0 with carry.
    a_limit = 8'd20;
    a_load_only(8'd12);
    check("a_at_max_off", {31'd0, a_at_max}, 32'd0);
    a_limit = 8'd10;
    repeat (2) @(negedge clk);
    check("a_limit_no_effect", {24'd0, a_out}, 32'd12);
    a_event(DIR_UP, 4);
    check("a_over_limit_out", {24'd0, a_at3_out}, 32'd0);
    check("a_over_limit_carry", {31'd0, a_at3_carry}, 32'd1);

    // Reset while an event is in the synchroniser discards it.
    @(negedge clk); a_cnt = 1'b1;
    @(negedge clk); reset = 1'b1; a_cnt = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (6) @(negedge clk);
    check("a_reset_discard", {24'd0, a_out}, 32'd0);

    // B: WIDTH=4, limit=0 wraps 15 -> 0 with carry.
    b_cycle(1'b0, DIR_UP, 1'b1, 4'd15, 4'd0);
    b_cycle(1'b1, DIR_UP, 1'b0, 4'd0, 4'd0);
    b_cycle(1'b0, DIR_UP, 1'b0, 4'd0, 4'd0);
    // 20 continuous cycles, limit 5: one count per cycle, 4 wraps.
    b_carries = 0;
    for (int i = 0; i < 20; i++) b_cycle(1'b1, DIR_UP, 1'b0, 4'd0, 4'd5);
    b_cycle(1'b0, DIR_UP, 1'b0, 4'd0, 4'd5);
    check("b_wrap_count", b_carries, 32'd4);
    check("b_level_out", {28'd0, b_out}, 32'd0);
    // Limit 1: every event wraps, giving back-to-back pulses.
    b_carries = 0;
    for (int i = 0; i < 3; i++) b_cycle(1'b1, DIR_UP, 1'b0, 4'd0, 4'd1);
    for (int i = 0; i < 2; i++) b_cycle(1'b1, DIR_DOWN, 1'b0, 4'd0, 4'd1);
    b_cycle(1'b0, DIR_UP, 1'b0, 4'd0, 4'd1);
    check("b_consec_carry", b_carries, 32'd3);

    // Cascade: 100 events on C1.
    c1_carries = 0; c2_carries = 0;
    @(negedge clk); c_cnt = 1'b1;
    repeat (100) @(negedge clk);
    c_cnt = 1'b0;
    repeat (3) @(negedge clk);
    check("c1_out", {24'd0, c1_out}, 32'd0);
    check("c2_out", {24'd0, c2_out}, 32'd0);
    check("c1_carries", c1_carries, 32'd10);
    check("c2_carries", c2_carries, 32'd1);

    // Cascade mid-run, then reset while C1's carry is high.
    @(negedge clk); c_cnt = 1'b1;
    repeat (30) @(negedge clk);
    check("c_mid_c1", {23'd0, c1_carry, c1_out}, {23'd0, 1'b1, 8'd0});
    check("c_mid_c2", {24'd0, c2_out}, 32'd2);
    reset = 1'b1; c_cnt = 1'b0;
    @(negedge clk); reset = 1'b0;
    check("rst_mid_c1", {22'd0, c1_carry, c1_borrow, c1_out}, 32'd0);
    check("rst_mid_c2", {22'd0, c2_carry, c2_borrow, c2_out}, 32'd0);
    check("rst_mid_a", {22'd0, a_carry, a_borrow, a_out}, 32'd0);
    check("rst_mid_b", {26'd0, b_carry, b_borrow, b_out}, 32'd0);

    repeat (3) @(negedge clk);
    check("a_queue_drained", exp_a_q.size(), 32'd0);
    check("b_queue_drained", exp_b_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
